// File: rtl/fir_cfg_pkg.sv
// Shared types for the FIR configuration controller: command opcodes,
// controller states and the coefficient width.
package fir_cfg_pkg;

  localparam int unsigned COEF_W = 8;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_MODE  = 2'b10,
    OP_CLEAR = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN    = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    COMMIT = 3'd4
  } state_e;

endpackage

// File: rtl/fir_cfg_ctrl_if.sv
// Byte-serial valid/ready configuration stream between a command source
// (master) and the FIR configuration controller (slave).
interface fir_cfg_ctrl_if;
  import fir_cfg_pkg::*;

  logic [COEF_W-1:0] cfg_byte;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_byte, output cfg_valid, input  cfg_ready);
  modport slave  (input  cfg_byte, input  cfg_valid, output cfg_ready);
endinterface

// File: rtl/fir_coef_bank.sv
// Shadow and active coefficient registers: writes land in the shadow bank,
// a commit copies the whole shadow into the active bank in one edge.
module fir_coef_bank
  import fir_cfg_pkg::*;
#(
  parameter int unsigned NTAPS = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [$clog2(NTAPS)-1:0]   widx,
  input  logic [COEF_W-1:0]          wdata,
  input  logic                       commit,
  input  logic                       clear,
  output logic [NTAPS*COEF_W-1:0]    coef
);

  typedef logic [NTAPS-1:0][COEF_W-1:0] bank_t;

  // Identity filter out of reset: tap0 = 1, all others 0.
  localparam bank_t RST_VAL = bank_t'({{((NTAPS-1)*COEF_W){1'b0}}, 8'h01});

  bank_t shadow_q, shadow_d;
  bank_t active_q, active_d;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (clear) begin
      shadow_d = '0;
      active_d = '0;
    end else begin
      if (we)     shadow_d[widx] = wdata;
      if (commit) active_d       = shadow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= RST_VAL;
      active_q <= RST_VAL;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign coef = active_q;

endmodule

// File: rtl/fir_cfg_ctrl.sv
// Command decoder for the FIR datapath: parses the byte stream, stages tap
// writes and commits them atomically. FIR_CFG_CHECKSUM_EN adds a sum byte check.
module fir_cfg_ctrl
  import fir_cfg_pkg::*;
#(
  parameter int unsigned NTAPS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fir_cfg_ctrl_if.slave            cfg,
  output logic [NTAPS*COEF_W-1:0]  coef,
  output logic                     coef_load,
  output logic                     fir_clr,
  output logic                     bypass,
  output logic                     busy,
  output logic                     err
);

  localparam int unsigned IW = $clog2(NTAPS);
  localparam int unsigned RW = IW + 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            bypass_q, bypass_d;
  logic            err_q, err_d;
  logic            coef_load_q, coef_load_d;
  logic            fir_clr_q, fir_clr_d;
`ifdef FIR_CFG_CHECKSUM_EN
  logic [COEF_W-1:0] sum_q, sum_d;
`endif

  logic            accept_c;
  opcode_e         op_c;
  logic            idx_ok_c;
  logic            len_ok_c;
  logic            bank_we_c, bank_commit_c, bank_clear_c;

  assign accept_c = cfg.cfg_valid && ready_q;
  assign op_c     = opcode_e'(cfg.cfg_byte[7:6]);
  assign idx_ok_c = ({1'b0, cfg.cfg_byte[3:0]} < 5'(NTAPS));
  assign len_ok_c = (cfg.cfg_byte != 8'd0) && (cfg.cfg_byte <= 8'(NTAPS));

  // Next-state and strobe decode; every strobe to the bank is combinational
  // so the bank acts on the same edge that accepts the byte.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rem_d         = rem_q;
    bypass_d      = bypass_q;
    err_d         = err_q;
    coef_load_d   = 1'b0;
    fir_clr_d     = 1'b0;
    bank_we_c     = 1'b0;
    bank_commit_c = 1'b0;
    bank_clear_c  = 1'b0;
`ifdef FIR_CFG_CHECKSUM_EN
    sum_d         = sum_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          case (op_c)
            OP_WRITE: begin
              if (idx_ok_c) begin
                idx_d   = cfg.cfg_byte[IW-1:0];
                state_d = LEN;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_MODE:  bypass_d = cfg.cfg_byte[0];
            OP_CLEAR: begin
              bank_clear_c = 1'b1;
              coef_load_d  = 1'b1;
              fir_clr_d    = 1'b1;
              err_d        = 1'b0;
            end
            default: ;
          endcase
        end
      end

      LEN: begin
        if (accept_c) begin
          if (len_ok_c) begin
            rem_d   = RW'(cfg.cfg_byte);
            state_d = DATA;
`ifdef FIR_CFG_CHECKSUM_EN
            sum_d   = '0;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (accept_c) begin
          bank_we_c = 1'b1;
          idx_d     = IW'(idx_q + IW'(1));
          rem_d     = RW'(rem_q - RW'(1));
`ifdef FIR_CFG_CHECKSUM_EN
          sum_d     = COEF_W'(sum_q + cfg.cfg_byte);
          if (rem_q == RW'(1)) state_d = CSUM;
`else
          if (rem_q == RW'(1)) state_d = COMMIT;
`endif
        end
      end

`ifdef FIR_CFG_CHECKSUM_EN
      CSUM: begin
        if (accept_c) begin
          if (cfg.cfg_byte == sum_q) begin
            state_d = COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif

      COMMIT: begin
        bank_commit_c = 1'b1;
        coef_load_d   = 1'b1;
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d != COMMIT);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rem_q       <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      bypass_q    <= 1'b0;
      err_q       <= 1'b0;
      coef_load_q <= 1'b0;
      fir_clr_q   <= 1'b0;
`ifdef FIR_CFG_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      bypass_q    <= bypass_d;
      err_q       <= err_d;
      coef_load_q <= coef_load_d;
      fir_clr_q   <= fir_clr_d;
`ifdef FIR_CFG_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  fir_coef_bank #(.NTAPS(NTAPS)) u_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (bank_we_c),
    .widx   (idx_q),
    .wdata  (cfg.cfg_byte),
    .commit (bank_commit_c),
    .clear  (bank_clear_c),
    .coef   (coef)
  );

  assign cfg.cfg_ready = ready_q;
  assign coef_load     = coef_load_q;
  assign fir_clr       = fir_clr_q;
  assign bypass        = bypass_q;
  assign busy          = busy_q;
  assign err           = err_q;

endmodule

// File: tb/tb_fir_cfg_ctrl.sv
// Bench for fir_cfg_ctrl (NTAPS = 8): command vector table plus hand-written
// latency, backpressure, error, checksum and async-reset sequences.
module tb_fir_cfg_ctrl;

  localparam int NT = 8;
  localparam logic [63:0] RST_COEF = 64'h0000_0000_0000_0001;

  logic        clk;
  logic        rst_n;
  logic [63:0] coef;
  logic        coef_load, fir_clr, bypass, busy, err;

  fir_cfg_ctrl_if ifc();

  fir_cfg_ctrl #(.NTAPS(NT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg       (ifc),
    .coef      (coef),
    .coef_load (coef_load),
    .fir_clr   (fir_clr),
    .bypass    (bypass),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int load_cnt = 0;
  int clr_cnt  = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [7:0]  hdr;
    logic [7:0]  len;
    logic [63:0] data;      // first data byte is the most significant of len bytes
    logic [63:0] exp_coef;
    logic        exp_load;
    logic        exp_bypass;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a byte and hold it until it is accepted; returns 1 time unit after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    ifc.cfg_byte  = b;
    ifc.cfg_valid = 1'b1;
    @(negedge clk);
    while (!ifc.cfg_ready && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 20) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout byte=%h ready=%b required=1", b, ifc.cfg_ready);
    end
    @(posedge clk);
    #1;
    ifc.cfg_valid = 1'b0;
  endtask

  task automatic send_wr(input logic [7:0] hdr, input logic [7:0] len, input logic [63:0] data);
    logic [7:0] d;
`ifdef FIR_CFG_CHECKSUM_EN
    logic [7:0] sum;
    sum = 8'h00;
`endif
    send_byte(hdr);
    send_byte(len);
    for (int k = 0; k < int'(len); k++) begin
      d = data[(int'(len) - 1 - k) * 8 +: 8];
`ifdef FIR_CFG_CHECKSUM_EN
      sum = sum + d;
`endif
      send_byte(d);
    end
`ifdef FIR_CFG_CHECKSUM_EN
    send_byte(sum);
`endif
  endtask

  // Scoreboard: every coef_load pulse must match the next queued commit.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fir_clr) clr_cnt++;
      if (coef_load) begin
        load_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_coef_load coef=%h required=no pulse", coef);
        end else begin
          chk("commit_coef", coef, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, c0;
    logic [7:0] lb;

    vt[0] = '{8'h42, 8'h03, 64'h112233,           64'hAA00_0033_2211_00BB & 64'h0000_0033_2211_0001, 1'b1, 1'b0};
    vt[0].exp_coef = 64'h0000_0033_2211_0001;
    vt[1] = '{8'h47, 8'h02, 64'hAABB,             64'hAA00_0033_2211_00BB, 1'b1, 1'b0};
    vt[2] = '{8'h81, 8'h00, 64'h0,                64'hAA00_0033_2211_00BB, 1'b0, 1'b1};
    vt[3] = '{8'h00, 8'h00, 64'h0,                64'hAA00_0033_2211_00BB, 1'b0, 1'b1};
    vt[4] = '{8'h40, 8'h01, 64'h5C,               64'hAA00_0033_2211_005C, 1'b1, 1'b1};
    vt[5] = '{8'h80, 8'h00, 64'h0,                64'hAA00_0033_2211_005C, 1'b0, 1'b0};
    vt[6] = '{8'h40, 8'h08, 64'h0102030405060708, 64'h0807_0605_0403_0201, 1'b1, 1'b0};

    rst_n = 1'b0;
    ifc.cfg_valid = 1'b0;
    ifc.cfg_byte  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    chk("rst_coef",      coef, RST_COEF);
    chk("rst_ready",     64'(ifc.cfg_ready), 1);
    chk("rst_busy",      64'(busy), 0);
    chk("rst_err",       64'(err), 0);
    chk("rst_bypass",    64'(bypass), 0);
    chk("rst_coef_load", 64'(coef_load), 0);
    chk("rst_fir_clr",   64'(fir_clr), 0);

    for (int i = 0; i < 7; i++) begin
      l0 = load_cnt;
      if (vt[i].exp_load) exp_q.push_back(vt[i].exp_coef);
      if (vt[i].hdr[7:6] == 2'b01) send_wr(vt[i].hdr, vt[i].len, vt[i].data);
      else                         send_byte(vt[i].hdr);
      idle(3);
      chk($sformatf("v%0d_coef", i),   coef, vt[i].exp_coef);
      chk($sformatf("v%0d_loads", i),  64'(load_cnt - l0), 64'(vt[i].exp_load));
      chk($sformatf("v%0d_bypass", i), 64'(bypass), 64'(vt[i].exp_bypass));
      chk($sformatf("v%0d_err", i),    64'(err), 0);
      chk($sformatf("v%0d_busy", i),   64'(busy), 0);
    end

    // Commit latency and coef stability while data is being staged.
    exp_q.push_back(64'h0807_0633_2211_0201);
    send_byte(8'h42); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    chk("data_coef_stable", coef, 64'h0807_0605_0403_0201);
    chk("data_busy", 64'(busy), 1);
`ifdef FIR_CFG_CHECKSUM_EN
    send_byte(8'h33);
    lb = 8'h66;
`else
    lb = 8'h33;
`endif
    l0 = load_cnt;
    send_byte(lb);
    chk("commit_ready_low", 64'(ifc.cfg_ready), 0);
    chk("commit_coef_held", coef, 64'h0807_0605_0403_0201);
    chk("commit_load_low",  64'(coef_load), 0);
    idle(1);
    chk("lat_coef",  coef, 64'h0807_0633_2211_0201);
    chk("lat_load",  64'(coef_load), 1);
    chk("lat_ready", 64'(ifc.cfg_ready), 1);
    idle(1);
    chk("lat_load_drop", 64'(coef_load), 0);
    chk("lat_loads", 64'(load_cnt - l0), 1);

    // Byte held across COMMIT must only be consumed once ready returns.
    exp_q.push_back(64'h0807_0633_2211_0277);
    send_byte(8'h40); send_byte(8'h01);
`ifdef FIR_CFG_CHECKSUM_EN
    send_byte(8'h77);
`endif
    ifc.cfg_byte  = 8'h77;
    ifc.cfg_valid = 1'b1;
    idle(1);
    ifc.cfg_byte = 8'h81;
    chk("bp_ready_low", 64'(ifc.cfg_ready), 0);
    idle(1);
    chk("bp_not_consumed", 64'(bypass), 0);
    chk("bp_load", 64'(coef_load), 1);
    idle(1);
    ifc.cfg_valid = 1'b0;
    chk("bp_consumed", 64'(bypass), 1);
    chk("bp_coef", coef, 64'h0807_0633_2211_0277);
    send_byte(8'h80);

    // Protocol errors, sticky err, and CLEAR.
    l0 = load_cnt;
    send_byte(8'h49);
    idle(1);
    chk("err_idx", 64'(err), 1);
    chk("err_idx_busy", 64'(busy), 0);
    send_byte(8'h40); send_byte(8'h00);
    idle(1);
    chk("err_len0", 64'(err), 1);
    chk("err_len0_busy", 64'(busy), 0);
    send_byte(8'h40); send_byte(8'h09);
    idle(2);
    chk("err_len9_busy", 64'(busy), 0);
    chk("err_no_loads", 64'(load_cnt - l0), 0);
    chk("err_coef_held", coef, 64'h0807_0633_2211_0277);
    exp_q.push_back(64'h0807_0633_2211_0299);
    send_wr(8'h40, 8'h01, 64'h99);
    idle(3);
    chk("err_write_coef", coef, 64'h0807_0633_2211_0299);
    chk("err_sticky", 64'(err), 1);
    exp_q.push_back(64'h0);
    l0 = load_cnt;
    c0 = clr_cnt;
    send_byte(8'hC0);
    chk("clr_fir_clr", 64'(fir_clr), 1);
    chk("clr_load", 64'(coef_load), 1);
    chk("clr_coef", coef, 64'h0);
    chk("clr_err", 64'(err), 0);
    idle(2);
    chk("clr_loads", 64'(load_cnt - l0), 1);
    chk("clr_pulses", 64'(clr_cnt - c0), 1);

`ifdef FIR_CFG_CHECKSUM_EN
    exp_q.push_back(64'h0000_0000_0000_2010);
    send_byte(8'h40); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    idle(3);
    chk("csum_ok_coef", coef, 64'h0000_0000_0000_2010);
    chk("csum_ok_err", 64'(err), 0);
    l0 = load_cnt;
    send_byte(8'h40); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h31);
    idle(3);
    chk("csum_bad_err", 64'(err), 1);
    chk("csum_bad_coef", coef, 64'h0000_0000_0000_2010);
    chk("csum_bad_loads", 64'(load_cnt - l0), 0);
`endif

    // Asynchronous reset in the middle of DATA discards the partial load.
    send_byte(8'h81);
    send_byte(8'h49);
    send_byte(8'h40); send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
    chk("pre_rst_busy", 64'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_coef",   coef, RST_COEF);
    chk("arst_bypass", 64'(bypass), 0);
    chk("arst_err",    64'(err), 0);
    chk("arst_busy",   64'(busy), 0);
    chk("arst_ready",  64'(ifc.cfg_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    chk("post_rst_coef", coef, RST_COEF);
    chk("post_rst_busy", 64'(busy), 0);
    exp_q.push_back(64'h0000_0000_0000_5501);
    send_wr(8'h41, 8'h01, 64'h55);
    idle(3);
    chk("post_rst_write", coef, 64'h0000_0000_0000_5501);

    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_cfg_ctrl.md
Name: fir_cfg_ctrl

Overview:
Byte-serial configuration controller for the FIR datapath. It decodes a command stream arriving on a valid/ready byte interface and stages coefficient writes in shadow registers. It commits all taps atomically to the active coefficient bus, and drives the datapath's clear and bypass controls. It sits between the top-level IO pins and the fir instance.

Parameters:
NTAPS, 8, number of filter taps (power of two, 2..16)
COEF_W, 8, coefficient width in bits (fixed to byte width of stream; must be 8)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cfg_byte  input  8  command/data byte
cfg_valid  input  1  cfg_byte valid
cfg_ready  output  1  controller can accept a byte
coef  output  NTAPS*COEF_W  active coefficients, tap i at bits [i*8 +: 8]
coef_load  output  1  one-cycle pulse when coef changes
fir_clr  output  1  one-cycle pulse that flushes the FIR delay line
bypass  output  1  1 = FIR output replaced by input sample
busy  output  1  high in any state other than IDLE
err  output  1  sticky protocol error flag

Behaviour:
- Single clock domain. Reset is asynchronous and active-low on rst_n. All state is registered.
- Reset values:
  - Active and shadow coefs: tap0 = 8'h01, all other taps 0.
  - coef_load = 0, fir_clr = 0, bypass = 0, err = 0, busy = 0.
  - State = IDLE, cfg_ready = 1.
- Byte transfer occurs on a rising edge with cfg_valid && cfg_ready.
- cfg_ready = 1 in IDLE, LEN, DATA and CSUM; 0 in COMMIT.
- Header opcode = cfg_byte[7:6]:
  - 00 NOP: no effect. Stay in IDLE.
  - 01 WRITE: cfg_byte[3:0] = start index. If the index is >= NTAPS, set err and stay in IDLE. Otherwise latch the index and go to LEN.
  - 10 MODE: bypass <= cfg_byte[0]. Takes effect on the accepting edge. Stay in IDLE.
  - 11 CLEAR: shadow and active coefs <= 0. Pulse coef_load and fir_clr for one cycle after the accepting edge. Clear err. Stay in IDLE.
- LEN: accepted byte L is the count of coefficients to follow.
  - If L == 0 or L > NTAPS, set err and return to IDLE.
  - Otherwise go to DATA with remaining = L.
- DATA: each accepted byte writes shadow[idx]. Then idx <= (idx+1) mod NTAPS (wrap-around is legal), and remaining decrements.
  - After the last byte: go to CSUM if FIR_CFG_CHECKSUM_EN is defined, else go to COMMIT.
- COMMIT: lasts exactly one cycle. Active <= shadow at the end of the cycle. coef_load is high for the following cycle, coincident with the new coef values. Then go to IDLE.
- Latency: last data byte accepted at edge t -> coef and coef_load update at edge t+1 -> cfg_ready high again from t+1.
- Shadow writes never reach coef before COMMIT. Untouched taps keep their prior shadow values.
- cfg_valid high while cfg_ready is low: the byte is not consumed; the source must hold it.
- Reset mid-transfer: returns to reset values and discards the partial load.
- err is sticky. It is cleared only by CLEAR or reset. Commands continue to be processed while err = 1.
- The idx counter is $clog2(NTAPS) bits wide. The remaining counter is $clog2(NTAPS)+1 bits wide.

Optional Feature:
FIR_CFG_CHECKSUM_EN
- Defined:
  - After L data bytes, one checksum byte is expected, equal to the sum of the L data bytes modulo 256.
  - On a match: go to COMMIT.
  - On a mismatch: set err, go to IDLE, no commit. The shadow keeps the partially written values, and they are discarded on the next successful WRITE of the same taps.
- Undefined: no CSUM state. DATA goes directly to COMMIT.

Decomposition:
- Package fir_cfg_pkg:
  - opcode enum (OP_NOP, OP_WRITE, OP_MODE, OP_CLEAR)
  - state enum (IDLE, LEN, DATA, CSUM, COMMIT)
  - localparam COEF_W = 8
- Sub-module fir_coef_bank: shadow and active register arrays, with a write port (idx, data, we), commit strobe, clear strobe, and flattened coef output. The FSM stays in fir_cfg_ctrl.

Test Plan:
- Reset: release rst_n -> coef = {0,...,0,8'h01}, cfg_ready = 1, busy = 0, err = 0, bypass = 0, no pulses.
- Write: bytes 8'h42, 8'h03, 8'h11, 8'h22, 8'h33 (idx 2, L = 3) -> taps 2/3/4 = 11/22/33 exactly one cycle after the last byte, coef_load high for 1 cycle, other taps unchanged, coef stable during DATA.
- Wrap: 8'h47, 8'h02, 8'hAA, 8'hBB with NTAPS = 8 -> tap7 = AA, tap0 = BB.
- Errors: 8'h49 (idx 9) -> err = 1, state IDLE. Then 8'h40, 8'h00 -> err stays 1, no coef_load. Then 8'hC0 -> all taps 0, fir_clr and coef_load pulse once, err = 0.
- Backpressure and reset: hold cfg_valid through COMMIT -> byte accepted only once cfg_ready returns. Assert rst_n = 0 mid-DATA -> all outputs return to reset values asynchronously.
- Checksum (macro defined): 8'h40, 8'h02, 8'h10, 8'h20, 8'h30 -> commit. Same sequence with 8'h31 as the checksum byte -> err = 1, coef unchanged, no coef_load.
